// File: rtl/ste_array_engine.sv
// State-transition-element array engine: one symbol per accepted handshake
// advances a configurable NFA of N_STE elements; reporting states are queued
// as {vector, symbol offset} entries in a first-word-fall-through FIFO.
module ste_array_engine #(
    parameter int  N_STE     = 16,
    parameter int  SYM_W     = 8,
    parameter int  RPT_DEPTH = 8,
    parameter int  OFS_W     = 32,
    localparam int IDX_W     = $clog2(N_STE),
    localparam int ARG_W     = (SYM_W > IDX_W) ? SYM_W : IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             flush,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_type,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [ARG_W-1:0] cfg_arg,
    input  logic [1:0]       cfg_val,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [SYM_W-1:0] symbols,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [N_STE-1:0] rpt_vec,
    output logic [OFS_W-1:0] rpt_ofs,
    output logic [N_STE-1:0] active
);

    localparam int N_SYM = 1 << SYM_W;
    localparam int PTR_W = $clog2(RPT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RPT_DEPTH - 1);
    localparam logic [IDX_W:0]   N_STE_L   = (IDX_W + 1)'(N_STE);

    typedef enum logic [1:0] {
        CFG_MATCH  = 2'd0,
        CFG_EDGE   = 2'd1,
        CFG_START  = 2'd2,
        CFG_REPORT = 2'd3
    } cfg_type_t;

    typedef enum logic [1:0] {
        START_NONE = 2'd0,
        START_SOD  = 2'd1,
        START_ALL  = 2'd2
    } start_t;

    // Configuration tables; match_tab is indexed by symbol so a lookup yields
    // the per-STE match vector directly. edge_tab[src][dst].
    logic [N_STE-1:0] match_tab [N_SYM];
    logic [N_STE-1:0] edge_tab  [N_STE];
    logic [1:0]       start_tab [N_STE];
    logic [N_STE-1:0] report_en;

    logic [OFS_W-1:0] offset;
    logic             sod;

    logic [N_STE-1:0] enable;
    logic [N_STE-1:0] next_active;
    logic [N_STE-1:0] report_hits;
    logic             accept;
    logic             push;
    logic             pop;

    logic [N_STE-1:0] vec_mem [RPT_DEPTH];
    logic [OFS_W-1:0] ofs_mem [RPT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             cfg_wr;
    logic             idx_ok;
    logic             src_ok;
    logic [SYM_W-1:0] cfg_sym;
    logic [IDX_W-1:0] cfg_src;

    assign cfg_sym = cfg_arg[SYM_W-1:0];
    assign cfg_src = cfg_arg[IDX_W-1:0];
    assign cfg_wr  = cfg_we && !run;
    assign idx_ok  = {1'b0, cfg_idx} < N_STE_L;
    assign src_ok  = {1'b0, cfg_src} < N_STE_L;

    // Configuration writes, only honoured while not running.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < N_SYM; s++) begin
                match_tab[s] <= '0;
            end
            for (int unsigned j = 0; j < N_STE; j++) begin
                edge_tab[j]  <= '0;
                start_tab[j] <= START_NONE;
            end
            report_en <= '0;
        end else if (cfg_wr && idx_ok) begin
            case (cfg_type_t'(cfg_type))
                CFG_MATCH:  match_tab[cfg_sym][cfg_idx] <= cfg_val[0];
                CFG_EDGE:   if (src_ok) edge_tab[cfg_src][cfg_idx] <= cfg_val[0];
                CFG_START:  start_tab[cfg_idx] <= cfg_val;
                CFG_REPORT: report_en[cfg_idx] <= cfg_val[0];
                default:    ;
            endcase
        end
    end

    // Enable vector: start conditions plus fan-out of currently active STEs.
    always_comb begin
        enable = '0;
        for (int unsigned i = 0; i < N_STE; i++) begin
            if (start_tab[i] == START_ALL || (start_tab[i] == START_SOD && sod)) begin
                enable[i] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < N_STE; j++) begin
            if (active[j]) begin
                enable = enable | edge_tab[j];
            end
        end
    end

    assign next_active = enable & match_tab[symbols];
    assign report_hits = next_active & report_en;

    // One FIFO slot is held back so a push never lands on a full FIFO.
    assign pop       = rpt_valid && rpt_ready;
    assign sym_ready = run && !flush && !reset && (count < CNT_LIMIT || pop);
    assign accept    = sym_valid && sym_ready;
    assign push      = accept && (report_hits != '0);

    // Active vector, symbol offset and start-of-data flag.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            active <= '0;
            offset <= '0;
            sod    <= 1'b1;
        end else if (accept) begin
            active <= next_active;
            offset <= offset + OFS_W'(1);
            sod    <= 1'b0;
        end
    end

    // Report storage; entries carry the offset of the symbol that produced them.
    always_ff @(posedge clk) begin
        if (push) begin
            vec_mem[wr_ptr] <= report_hits;
            ofs_mem[wr_ptr] <= offset;
        end
    end

    // Report FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rpt_valid = (count != '0);
    assign rpt_vec   = vec_mem[rd_ptr];
    assign rpt_ofs   = ofs_mem[rd_ptr];

endmodule

// File: tb/tb_ste_array_engine.sv
// Testbench for ste_array_engine: a queue-based reference model checked on
// every cycle against two instances (32-bit and 4-bit offset counters), plus
// directed scenarios with hand-computed expectations.
module tb_ste_array_engine;

    localparam int N = 16;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset, run, flush, cfg_we;
    logic [1:0]  cfg_type, cfg_val;
    logic [3:0]  cfg_idx;
    logic [7:0]  cfg_arg;
    logic        sym_valid;
    logic [7:0]  symbols;
    logic        rpt_ready;

    logic        sym_ready, rpt_valid;
    logic [15:0] rpt_vec, active;
    logic [31:0] rpt_ofs;
    logic        sym_ready_w, rpt_valid_w;
    logic [15:0] rpt_vec_w, active_w;
    logic [3:0]  rpt_ofs_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ste_array_engine #(.N_STE(N), .SYM_W(8), .RPT_DEPTH(D), .OFS_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .flush(flush), .cfg_we(cfg_we),
        .cfg_type(cfg_type), .cfg_idx(cfg_idx), .cfg_arg(cfg_arg), .cfg_val(cfg_val),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .symbols(symbols),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec),
        .rpt_ofs(rpt_ofs), .active(active)
    );

    ste_array_engine #(.N_STE(N), .SYM_W(8), .RPT_DEPTH(D), .OFS_W(4)) dut_w (
        .clk(clk), .reset(reset), .run(run), .flush(flush), .cfg_we(cfg_we),
        .cfg_type(cfg_type), .cfg_idx(cfg_idx), .cfg_arg(cfg_arg), .cfg_val(cfg_val),
        .sym_valid(sym_valid), .sym_ready(sym_ready_w), .symbols(symbols),
        .rpt_valid(rpt_valid_w), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec_w),
        .rpt_ofs(rpt_ofs_w), .active(active_w)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [15:0] vec;
        logic [63:0] ofs;
    } rpt_t;

    typedef struct {
        logic [15:0] vec;
        logic [31:0] ofs;
        logic [3:0]  ofs4;
    } got_t;

    bit          m_match [256][16];
    bit          m_edge  [16][16];
    int          m_start [16];
    bit          m_rep   [16];
    logic [15:0] m_act;
    logic [63:0] m_ofs;
    bit          m_sod;
    rpt_t        m_q[$];
    bit          live = 1'b0;
    got_t        got[$];

    function automatic bit m_ready();
        return run && !flush && !reset &&
               (m_q.size() < D - 1 || (m_q.size() > 0 && rpt_ready));
    endfunction

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step();
        logic [15:0] nxt, rv;
        bit en, rdy, pop;
        rpt_t e;
        if (reset) begin
            for (int s = 0; s < 256; s++)
                for (int i = 0; i < 16; i++) m_match[s][i] = 1'b0;
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) m_edge[j][i] = 1'b0;
                m_start[j] = 0;
                m_rep[j]   = 1'b0;
            end
            m_act = '0;
            m_ofs = '0;
            m_sod = 1'b1;
            m_q.delete();
            live = 1'b1;
        end else begin
            rdy = m_ready();
            pop = (m_q.size() > 0) && rpt_ready;
            if (cfg_we && !run) begin
                case (cfg_type)
                    2'd0: m_match[cfg_arg][cfg_idx] = cfg_val[0];
                    2'd1: m_edge[cfg_arg[3:0]][cfg_idx] = cfg_val[0];
                    2'd2: m_start[cfg_idx] = int'(cfg_val);
                    default: m_rep[cfg_idx] = cfg_val[0];
                endcase
            end
            if (pop) void'(m_q.pop_front());
            if (flush) begin
                m_act = '0;
                m_ofs = '0;
                m_sod = 1'b1;
            end else if (sym_valid && rdy) begin
                nxt = '0;
                rv  = '0;
                for (int i = 0; i < 16; i++) begin
                    en = (m_start[i] == 2) || (m_start[i] == 1 && m_sod);
                    for (int j = 0; j < 16; j++)
                        if (m_act[j] && m_edge[j][i]) en = 1'b1;
                    nxt[i] = en && m_match[symbols][i];
                    rv[i]  = nxt[i] && m_rep[i];
                end
                if (rv != '0) begin
                    e.vec = rv;
                    e.ofs = m_ofs;
                    m_q.push_back(e);
                end
                m_act = nxt;
                m_ofs = m_ofs + 64'd1;
                m_sod = 1'b0;
            end
        end
    endtask

    // Compare DUT outputs to the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (live) begin
            chk("sym_ready", sym_ready, m_ready());
            chk("sym_ready_w", sym_ready_w, m_ready());
            chk("active", active, m_act);
            chk("active_w", active_w, m_act);
            chk("rpt_valid", rpt_valid, m_q.size() != 0);
            chk("rpt_valid_w", rpt_valid_w, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("rpt_vec", rpt_vec, m_q[0].vec);
                chk("rpt_ofs", rpt_ofs, m_q[0].ofs[31:0]);
                chk("rpt_vec_w", rpt_vec_w, m_q[0].vec);
                chk("rpt_ofs_w", rpt_ofs_w, m_q[0].ofs[3:0]);
            end
            if (rpt_valid && rpt_ready) got.push_back('{rpt_vec, rpt_ofs, rpt_ofs_w});
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sym_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b1; sym_valid = 1'b1; flush = 1'b0; cfg_we = 1'b0;
        rpt_ready = 1'b0;
        tick();
        #1 chk("reset_sym_ready", sym_ready, 1'b0);
        tick();
        reset = 1'b0; run = 1'b0; sym_valid = 1'b0;
        #1;
        chk("reset_active", active, 16'h0);
        chk("reset_rpt_valid", rpt_valid, 1'b0);
        got.delete();
    endtask

    task automatic cfg(input int t, input int idx, input int arg, input int val);
        run = 1'b0; cfg_we = 1'b1;
        cfg_type = 2'(t); cfg_idx = 4'(idx); cfg_arg = 8'(arg); cfg_val = 2'(val);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic match_all(input int ste);
        for (int s = 0; s < 256; s++) cfg(0, ste, s, 1);
    endtask

    task automatic send(input int s);
        bit ok = 1'b0;
        bit rdy;
        sym_valid = 1'b1;
        symbols   = 8'(s);
        for (int k = 0; k < 200; k++) begin
            #1 rdy = sym_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        sym_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: symbol %0h not accepted, required accept within 200 cycles", s);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1; sym_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        reset = 1'b1; run = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_type = '0;
        cfg_idx = '0; cfg_arg = '0; cfg_val = '0; sym_valid = 1'b0; symbols = '0;
        rpt_ready = 1'b0;

        // Start-of-data chain, then a write attempted while running
        do_reset();
        cfg(2, 0, 0, 1);
        for (int s = 0; s < 16; s++) cfg(0, 0, s, 1);
        cfg(1, 1, 0, 1);
        cfg(0, 1, 8'h10, 1);
        cfg(3, 1, 0, 1);
        run = 1'b1; rpt_ready = 1'b1;
        send(8'h05);
        send(8'h10);
        idle(4);
        chk("sod_chain_count", got.size(), 1);
        if (got.size() > 0) begin
            chk("sod_chain_vec", got[0].vec, 16'h0002);
            chk("sod_chain_ofs", got[0].ofs, 32'd1);
        end
        cfg_we = 1'b1; cfg_type = 2'd0; cfg_idx = 4'd1; cfg_arg = 8'h10; cfg_val = 2'd0;
        tick();
        cfg_we = 1'b0;
        do_flush();
        send(8'h05);
        send(8'h10);
        idle(4);
        chk("guard_count", got.size(), 2);
        if (got.size() > 1) begin
            chk("guard_vec", got[1].vec, 16'h0002);
            chk("guard_ofs", got[1].ofs, 32'd1);
        end

        // Self-loop across 1000 symbols
        do_reset();
        cfg(2, 0, 0, 2);
        match_all(0);
        cfg(1, 0, 0, 1);
        cfg(1, 2, 0, 1);
        cfg(0, 2, 8'hFF, 1);
        cfg(3, 2, 0, 1);
        run = 1'b1; rpt_ready = 1'b1;
        for (int k = 0; k < 1000; k++) send(int'($urandom_range(0, 254)));
        send(8'hFF);
        idle(3);
        chk("loop_count", got.size(), 1);
        if (got.size() > 0) begin
            chk("loop_vec", got[0].vec, 16'h0004);
            chk("loop_ofs", got[0].ofs, 32'd1000);
            chk("loop_ofs4", got[0].ofs4, 4'd8);
        end
        chk("loop_active0", active[0], 1'b1);

        // Backpressure: fill the FIFO, then drain
        do_reset();
        cfg(2, 0, 0, 2);
        match_all(0);
        cfg(3, 0, 0, 1);
        run = 1'b1; rpt_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            sym_valid = 1'b1;
            symbols = 8'($urandom);
            #1 if (sym_ready) acc++;
            tick();
        end
        #1 chk("bp_sym_ready_low", sym_ready, 1'b0);
        chk("bp_accepts", acc, D - 1);
        sym_valid = 1'b0;
        rpt_ready = 1'b1;
        idle(12);
        chk("bp_drain_count", got.size(), D - 1);
        for (int k = 0; k < got.size(); k++) begin
            chk("bp_drain_ofs", got[k].ofs, k);
            chk("bp_drain_vec", got[k].vec, 16'h0001);
        end

        // Flush mid-stream with sym_valid held high
        do_reset();
        cfg(2, 0, 0, 1);
        cfg(0, 0, 8'h41, 1);
        cfg(3, 0, 0, 1);
        cfg(2, 1, 0, 2);
        cfg(0, 1, 8'h42, 1);
        run = 1'b1; rpt_ready = 1'b1;
        send(8'h41);
        send(8'h42);
        send(8'h42);
        chk("fl_pre_active", active, 16'h0002);
        flush = 1'b1; sym_valid = 1'b1; symbols = 8'h41;
        #1 chk("fl_sym_ready", sym_ready, 1'b0);
        tick();
        flush = 1'b0; sym_valid = 1'b0;
        #1 chk("fl_active", active, 16'h0);
        send(8'h41);
        idle(3);
        chk("fl_count", got.size(), 2);
        if (got.size() > 1) begin
            chk("fl_first_ofs", got[0].ofs, 32'd0);
            chk("fl_after_vec", got[1].vec, 16'h0001);
            chk("fl_after_ofs", got[1].ofs, 32'd0);
        end

        // Offset wrap on the 4-bit instance
        do_reset();
        cfg(2, 0, 0, 2);
        match_all(0);
        cfg(3, 0, 0, 1);
        run = 1'b1; rpt_ready = 1'b1;
        for (int k = 0; k < 17; k++) send(int'($urandom_range(0, 255)));
        idle(3);
        chk("wrap_count", got.size(), 17);
        if (got.size() > 16) begin
            chk("wrap_ofs4_15", got[15].ofs4, 4'd15);
            chk("wrap_ofs4_16", got[16].ofs4, 4'd0);
            chk("wrap_ofs32_16", got[16].ofs, 32'd16);
        end

        // Random traffic: config, run toggles, flushes, backpressure
        do_reset();
        cfg(2, 0, 0, 1);
        cfg(2, 1, 0, 2);
        for (int k = 0; k < 60; k++) begin
            int t;
            t = int'($urandom_range(0, 3));
            cfg(t, int'($urandom_range(0, 15)),
                (t == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 3000; k++) begin
            run       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_type  = 2'($urandom_range(0, 3));
            cfg_idx   = 4'($urandom_range(0, 15));
            cfg_arg   = 8'($urandom_range(0, 7));
            cfg_val   = 2'($urandom_range(0, 3));
            sym_valid = ($urandom_range(0, 3) != 0);
            symbols   = ($urandom_range(0, 7) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            rpt_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        run = 1'b0; flush = 1'b0; cfg_we = 1'b0; sym_valid = 1'b0; rpt_ready = 1'b1;
        idle(12);
        chk("final_drained", rpt_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
